// File: rtl/seven_seg_capture.sv
// seven_seg_capture: rebuilds the four digits shown on a multiplexed,
// active-low seven-segment display. A pattern is captured once it has been
// stable for SETTLE_CYCLES sampled cycles. A frame is published after all four
// slots have been captured.
// Build option: define CAPTURE_HEX_EN to also decode the letters A..F.
module seven_seg_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        btnR,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        frame_err,
  output logic        frame_valid,
  output logic        stale
);

  localparam int         TW     = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SET8   = 8'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  logic [6:0]    s_seg_q, s_seg_d;
  logic [3:0]    s_an_q, s_an_d;
  logic [10:0]   prev_q, prev_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [3:0]    seen_q, seen_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    sh_blank_q, sh_blank_d;
  logic [3:0]    sh_err_q, sh_err_d;
  logic [15:0]   digits_q, digits_d;
  logic [3:0]    blank_q, blank_d;
  logic          frame_err_q, frame_err_d;
  logic          frame_valid_q, frame_valid_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic          valid;
  logic          same;
  logic          capture;
  logic [1:0]    slot;
  logic [5:0]    dec;

  // Returns {err, blank, value} for one active-low segment pattern.
  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = {2'b00, 4'h0};
      7'h79:   decode = {2'b00, 4'h1};
      7'h24:   decode = {2'b00, 4'h2};
      7'h30:   decode = {2'b00, 4'h3};
      7'h19:   decode = {2'b00, 4'h4};
      7'h12:   decode = {2'b00, 4'h5};
      7'h02:   decode = {2'b00, 4'h6};
      7'h78:   decode = {2'b00, 4'h7};
      7'h00:   decode = {2'b00, 4'h8};
      7'h10:   decode = {2'b00, 4'h9};
      7'h7F:   decode = {2'b01, 4'h0};
`ifdef CAPTURE_HEX_EN
      7'h08:   decode = {2'b00, 4'hA};
      7'h03:   decode = {2'b00, 4'hB};
      7'h46:   decode = {2'b00, 4'hC};
      7'h21:   decode = {2'b00, 4'hD};
      7'h06:   decode = {2'b00, 4'hE};
      7'h0E:   decode = {2'b00, 4'hF};
`endif
      default: decode = {2'b10, 4'h0};
    endcase
  endfunction

  // Next-state logic: input sampling, settle counting, capture, publish and timeout.
  always_comb begin
    s_seg_d       = seg;
    s_an_d        = an;
    prev_d        = {s_an_q, s_seg_q};
    cnt_d         = cnt_q;
    seen_d        = seen_q;
    shadow_d      = shadow_q;
    sh_blank_d    = sh_blank_q;
    sh_err_d      = sh_err_q;
    digits_d      = digits_q;
    blank_d       = blank_q;
    frame_err_d   = frame_err_q;
    frame_valid_d = 1'b0;
    to_cnt_d      = to_cnt_q;
    valid         = 1'b1;
    slot          = 2'd0;
    capture       = 1'b0;
    dec           = decode(s_seg_q);

    case (s_an_q)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: valid = 1'b0;
    endcase

    // A zero count means there is no valid pattern to continue.
    same = ({s_an_q, s_seg_q} == prev_q) && (cnt_q != 8'd0);

    if (!valid) begin
      cnt_d = 8'd0;
    end else if (same) begin
      if (cnt_q != SET8) begin
        cnt_d   = cnt_q + 8'd1;
        capture = ((cnt_q + 8'd1) == SET8);
      end
    end else begin
      cnt_d   = 8'd1;
      capture = (SET8 == 8'd1);
    end

    // The publish logic runs first so that a capture in the same cycle lands in the next frame.
    if (seen_q == 4'hF) begin
      digits_d      = shadow_q;
      blank_d       = sh_blank_q;
      frame_err_d   = |sh_err_q;
      frame_valid_d = 1'b1;
      seen_d        = 4'h0;
      sh_err_d      = 4'h0;
    end

    if (capture) begin
      shadow_d[{slot, 2'b00} +: 4] = dec[3:0];
      sh_blank_d[slot]             = dec[4];
      sh_err_d[slot]               = dec[5];
      seen_d[slot]                 = 1'b1;
    end

    if (frame_valid_q) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (btnR) begin
      s_seg_q       <= '0;
      s_an_q        <= '0;
      prev_q        <= '0;
      cnt_q         <= '0;
      seen_q        <= '0;
      shadow_q      <= '0;
      sh_blank_q    <= '0;
      sh_err_q      <= '0;
      digits_q      <= '0;
      blank_q       <= '0;
      frame_err_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      s_seg_q       <= s_seg_d;
      s_an_q        <= s_an_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      shadow_q      <= shadow_d;
      sh_blank_q    <= sh_blank_d;
      sh_err_q      <= sh_err_d;
      digits_q      <= digits_d;
      blank_q       <= blank_d;
      frame_err_q   <= frame_err_d;
      frame_valid_q <= frame_valid_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign digits      = digits_q;
  assign blank       = blank_q;
  assign frame_err   = frame_err_q;
  assign frame_valid = frame_valid_q;
  assign stale       = (to_cnt_q == TO_MAX);

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture. It uses directed scans followed by random
// scans. A frame-level reference model predicts every published frame and its
// publish cycle, and it also predicts the stale flag.
module tb_seven_seg_capture;

  localparam int S = 4;
  localparam int T = 200;

  logic        clk = 1'b0;
  logic        btnR = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        frame_err;
  logic        frame_valid;
  logic        stale;

  seven_seg_capture #(.SETTLE_CYCLES(S), .TIMEOUT(T)) dut (
    .clk(clk), .btnR(btnR), .seg(seg), .an(an),
    .digits(digits), .blank(blank), .frame_err(frame_err),
    .frame_valid(frame_valid), .stale(stale)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [15:0] d;
    logic [3:0]  b;
    logic        e;
  } frame_t;

  frame_t      fq[$];
  logic [6:0]  dec_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0]  hex_tab[6]  = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0]  bad_an[5]   = '{7'h0F, 7'h00, 7'h0C, 7'h03, 7'h09};
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          z = 0;
  int          run_len = 0;
  logic [10:0] run_pat = '1;
  logic [15:0] m_val = '0;
  logic [3:0]  m_blank = '0, m_err = '0, m_seen = '0;
  int          model_frames = 0;
  int          dut_frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the digit and letter tables: {err, blank, value}.
  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    if (p == 7'h7F) return 6'b01_0000;
    for (int i = 0; i < 10; i++) if (dec_tab[i] == p) return {2'b00, 4'(i)};
`ifdef CAPTURE_HEX_EN
    for (int i = 0; i < 6; i++) if (hex_tab[i] == p) return {2'b00, 4'(10 + i)};
`endif
    return 6'b10_0000;
  endfunction

  task automatic do_reset();
    btnR = 1'b1; an = 4'hF; seg = 7'h7F;
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    chk("rst_digits", 32'(digits), 0);
    chk("rst_blank", 32'(blank), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_fv", 32'(frame_valid), 0);
    chk("rst_stale", 32'(stale), 0);
    btnR = 1'b0;
    z = cyc;
    fq.delete();
    m_val = '0; m_blank = '0; m_err = '0; m_seen = '0;
    run_pat = '1; run_len = 0;
  endtask

  task automatic tick(input logic [3:0] a, input logic [6:0] s);
    logic [5:0] d;
    int         k;
    frame_t     f;
    logic       fv_exp;
    an = a; seg = s;
    @(posedge clk); cyc++;
    if ({a, s} == run_pat) run_len++;
    else begin run_pat = {a, s}; run_len = 1; end
    if ($countones(~a) == 1 && run_len == S) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) k = i;
      d = ref_decode(s);
      m_val[k*4 +: 4] = d[3:0];
      m_blank[k] = d[4];
      m_err[k] = d[5];
      m_seen[k] = 1'b1;
      if (m_seen == 4'hF) begin
        f.t = cyc + 2; f.d = m_val; f.b = m_blank; f.e = |m_err;
        fq.push_back(f);
        model_frames++;
        m_seen = '0; m_err = '0;
      end
    end
    #1;
    if (frame_valid) dut_frames++;
    chk("stale", 32'(stale), 32'((cyc - z) >= T));
    fv_exp = (fq.size() > 0) && (fq[0].t == cyc);
    chk("frame_valid", 32'(frame_valid), 32'(fv_exp));
    if (fv_exp) begin
      chk("digits", 32'(digits), 32'(fq[0].d));
      chk("blank", 32'(blank), 32'(fq[0].b));
      chk("frame_err", 32'(frame_err), 32'(fq[0].e));
      void'(fq.pop_front());
      z = cyc + 1;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) tick(a, s);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3, input int n);
    hold(4'hE, s0, n); hold(4'hD, s1, n); hold(4'hB, s2, n); hold(4'h7, s3, n);
  endtask

  initial begin
    int n0;
    logic [3:0] ra;
    logic [6:0] rs;
    int r;

    do_reset();
    scan(7'h40, 7'h79, 7'h24, 7'h30, 8);
    chk("scan_digits", 32'(digits), 32'h3210);
    chk("scan_blank", 32'(blank), 0);
    chk("scan_err", 32'(frame_err), 0);

    scan(7'h12, 7'h7F, 7'h12, 7'h12, 8);
    chk("blank_digits", 32'(digits), 32'h5505);
    chk("blank_mask", 32'(blank), 32'b0010);

    hold(4'hC, 7'h40, 20);
    scan(7'h10, 7'h00, 7'h78, 7'h02, 8);
    chk("multi_an_digits", 32'(digits), 32'h6789);

    scan(7'h40, 7'h40, 7'h08, 7'h40, 8);
`ifdef CAPTURE_HEX_EN
    chk("hex_digits", 32'(digits), 32'h0A00);
    chk("hex_err", 32'(frame_err), 0);
`else
    chk("hex_digits", 32'(digits), 32'h0000);
    chk("hex_err", 32'(frame_err), 1);
`endif

    do_reset();
    n0 = dut_frames;
    hold(4'hE, 7'h40, 8); hold(4'hD, 7'h79, 8); hold(4'hB, 7'h24, 8);
    do_reset();
    chk("midscan_none", 32'(dut_frames - n0), 0);
    scan(7'h19, 7'h12, 7'h02, 7'h78, 8);
    hold(4'hF, 7'h7F, 3);
    chk("midscan_one", 32'(dut_frames - n0), 1);
    chk("midscan_digits", 32'(digits), 32'h7654);

    do_reset();
    n0 = dut_frames;
    for (int i = 0; i < (T + 30) / 12; i++) scan(7'h40, 7'h79, 7'h24, 7'h30, 3);
    chk("short_no_frame", 32'(dut_frames - n0), 0);
    chk("short_stale", 32'(stale), 1);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) ra = ~(4'b0001 << $urandom_range(0, 3));
      else       ra = bad_an[$urandom_range(0, 4)][3:0];
      r = $urandom_range(0, 15);
      if (r < 10)      rs = dec_tab[r];
      else if (r == 10) rs = 7'h7F;
      else if (r < 14)  rs = hex_tab[$urandom_range(0, 5)];
      else              rs = 7'($urandom);
      hold(ra, rs, $urandom_range(1, 9));
    end
    hold(4'hF, 7'h7F, 4);
    chk("frame_count", 32'(dut_frames), 32'(model_frames));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Reader for the multiplexed seven-segment display that the stopwatch `clock` module drives. It watches the active-low `seg`/`an` outputs and rebuilds the four displayed digits as 4-bit values.
- It publishes one complete frame per scan with a one-cycle strobe.
- Used as a self-checking monitor in stopwatch benches and as a loopback checker on the board.

Parameters:
- SETTLE_CYCLES, 4: consecutive sampled cycles a pattern must hold before capture; legal 1..255.
- TIMEOUT, 1024: cycles with no frame published before `stale` asserts; legal 2..2^20.

Ports:
- clk  in  1  system clock; single clock domain.
- btnR  in  1  reset; synchronous, active-high.
- seg  in  7  segment lines, active-low, {g,f,e,d,c,b,a}, same domain as clk.
- an  in  4  anode lines, active-low; an[0] selects the rightmost digit (digit0).
- digits  out  16  last published frame; digits[3:0] is digit0 and digits[15:12] is digit3.
- blank  out  4  per-digit flag: that digit was dark (seg = 7'h7F) in the published frame.
- frame_err  out  1  published frame contained at least one undecodable pattern.
- frame_valid  out  1  one-cycle strobe; the published outputs were updated this cycle.
- stale  out  1  no frame published for TIMEOUT cycles.

Behaviour:
- Reset values: digits = 0, blank = 0, frame_err = 0, frame_valid = 0, stale = 0. All internal state also clears: sample registers, settle counter, seen[3:0], shadow slots, timeout counter.
- Input stage: `seg` and `an` are registered once into s_seg and s_an.
- Valid pattern: s_an has exactly one bit low. Zero or multiple low bits means invalid: the settle counter clears and nothing is captured.
- Settle counter:
  - Increments while {s_an, s_seg} equals its previous value and is valid; otherwise it reloads to 1 on a new valid pattern.
  - Capture fires once, on the cycle the counter reaches SETTLE_CYCLES. The counter then saturates, so a long dwell captures only once.
- Capture into the slot selected by s_an:
  - Decimal decode (hex): 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10.
  - 7F: value 0, blank bit set.
  - Any other pattern: value 4'h0, and the slot's error bit is set.
  - seen[slot] is set. Recapturing an already-seen slot overwrites it (latest wins).
- Publish:
  - On the cycle after seen becomes 4'b1111, copy the shadow slots to digits, blank and frame_err; pulse frame_valid for one cycle.
  - In the same cycle, clear seen and the slot error bits.
  - Latency from the pattern appearing on the ports to capture is SETTLE_CYCLES+1 edges; publish follows one edge after the last capture.
- Simultaneous events: a capture in the publish cycle lands in the new frame (seen is cleared, then that bit is set).
- Timeout:
  - Counter clears on frame_valid and increments otherwise, saturating at TIMEOUT.
  - stale = (count == TIMEOUT); it drops on the cycle after the next frame_valid.
- Reset mid-scan discards the partial frame; the first frame after reset needs all four slots captured again.

Optional Feature:
- CAPTURE_HEX_EN
  - Defined: additionally decode A:08, b:03, C:46, d:21, E:06, F:0E to values 4'hA..4'hF, with no error.
  - Undefined: these patterns are undecodable and set frame_err in the published frame.

Test Plan:
- Scan `an` = E,D,B,7 with seg = 40,79,24,30, each held 8 cycles (SETTLE_CYCLES=4) -> one frame_valid; digits = 16'h3210, blank = 0, frame_err = 0.
- Drive digit1 with seg = 7F and the others with 12 -> digits = 16'h5505, blank = 4'b0010.
- Drive `an` = 4'hC (two anodes low) for 20 cycles, then a normal scan -> no capture during the 4'hC window; the frame reflects only the normal scan.
- Hold each pattern for only 3 cycles (< SETTLE_CYCLES) -> frame_valid never asserts; stale rises exactly TIMEOUT cycles after reset.
- Digit2 seg = 08 -> without CAPTURE_HEX_EN, frame_err = 1; with the macro defined, digits[11:8] = 4'hA and frame_err = 0.
- Assert btnR after 3 of the 4 slots are captured, then scan all 4 -> no publish before reset; exactly one frame_valid after the full post-reset scan, all outputs 0 until then.
